// File: rtl/keccak_squeeze_bytes_if.sv
// Bundle of request, byte-stream and permutation signals for keccak_squeeze_bytes.
// The optional perm_count member is present only when KECCAK_SQZ_PERM_CNT_EN is defined.
interface keccak_squeeze_bytes_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic [1599:0]    s_in;
    logic [31:0]      pos_in;
    logic [31:0]      r;
    logic [LEN_W-1:0] outlen;

    logic [7:0]       out_byte;
    logic             out_valid;
    logic             out_ready;

    logic             perm_start;
    logic [1599:0]    perm_s_out;
    logic [1599:0]    perm_s_in;
    logic             perm_done;

    logic [1599:0]    s_out;
    logic [31:0]      pos_out;
    logic             done;
`ifdef KECCAK_SQZ_PERM_CNT_EN
    logic [15:0]      perm_count;
`endif

    modport master (
`ifdef KECCAK_SQZ_PERM_CNT_EN
        input  perm_count,
`endif
        output start, s_in, pos_in, r, outlen, out_ready, perm_s_in, perm_done,
        input  out_byte, out_valid, perm_start, perm_s_out, s_out, pos_out, done
    );

    modport slave (
`ifdef KECCAK_SQZ_PERM_CNT_EN
        output perm_count,
`endif
        input  start, s_in, pos_in, r, outlen, out_ready, perm_s_in, perm_done,
        output out_byte, out_valid, perm_start, perm_s_out, s_out, pos_out, done
    );
endinterface

// File: rtl/keccak_squeeze_bytes.sv
// Byte-wise Keccak squeeze over valid/ready, requesting an external permutation lazily.
// Define KECCAK_SQZ_PERM_CNT_EN to add the saturating perm_count output.
module keccak_squeeze_bytes #(
    parameter int LEN_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    keccak_squeeze_bytes_if.slave bus
);
    localparam int NUM_BYTES = 200;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        EMIT,
        PERM_REQ,
        PERM_WAIT,
        DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [1599:0]           st;
    logic [31:0]             pos;
    logic [31:0]             r_q;
    logic [LEN_W-1:0]        remaining;
    logic [31:0]             pos_out_q;

    logic                    capture;
    logic                    fire;
    logic                    perm_load;
    logic [31:0]             pos_inc;
    logic [NUM_BYTES-1:0][7:0] st_bytes;

    assign pos_inc  = pos + 32'd1;
    // Byte k of the packed view is bits [8k+7:8k], i.e. lane k/8 shifted by 8*(k%8).
    assign st_bytes = st;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        fire      = 1'b0;
        perm_load = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    capture   = 1'b1;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (remaining == '0)  state_nxt = DONE;
                else if (pos == r_q)  state_nxt = PERM_REQ;
                else                  state_nxt = EMIT;
            end
            EMIT: begin
                if (bus.out_ready) begin
                    fire = 1'b1;
                    if (remaining == LEN_W'(1))  state_nxt = DONE;
                    else if (pos_inc == r_q)     state_nxt = PERM_REQ;
                    else                         state_nxt = EMIT;
                end
            end
            PERM_REQ: state_nxt = PERM_WAIT;
            PERM_WAIT: begin
                if (bus.perm_done) begin
                    perm_load = 1'b1;
                    state_nxt = CHECK;
                end
            end
            DONE: begin
                if (!bus.start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st        <= '0;
            pos       <= '0;
            r_q       <= '0;
            remaining <= '0;
            pos_out_q <= '0;
        end else begin
            if (capture) begin
                st        <= bus.s_in;
                pos       <= bus.pos_in;
                r_q       <= bus.r;
                remaining <= bus.outlen;
            end else if (fire) begin
                pos       <= pos_inc;
                remaining <= remaining - LEN_W'(1);
            end else if (perm_load) begin
                st        <= bus.perm_s_in;
                pos       <= '0;
            end
            // Latch the final offset on the way into DONE so it is valid with done.
            if (state_nxt == DONE && state != DONE)
                pos_out_q <= fire ? pos_inc : pos;
        end
    end

    always_comb begin
        bus.out_byte = 8'h00;
        if (pos < 32'(NUM_BYTES)) bus.out_byte = st_bytes[pos[7:0]];
    end

    assign bus.out_valid  = (state == EMIT);
    assign bus.perm_start = (state == PERM_REQ);
    assign bus.done       = (state == DONE);
    assign bus.perm_s_out = st;
    assign bus.s_out      = st;
    assign bus.pos_out    = pos_out_q;

`ifdef KECCAK_SQZ_PERM_CNT_EN
    logic [15:0] perm_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            perm_cnt <= '0;
        else if (capture)
            perm_cnt <= '0;
        else if (state == PERM_REQ && perm_cnt != 16'hFFFF)
            perm_cnt <= perm_cnt + 16'd1;
    end

    assign bus.perm_count = perm_cnt;
`else
    // No permutation counter in this build.
`endif
endmodule

// File: tb/tb_keccak_squeeze_bytes.sv
// Self-checking bench: vector table plus scoreboard queue of expected bytes.
module tb_keccak_squeeze_bytes;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    keccak_squeeze_bytes_if #(.LEN_W(16)) bus ();

    keccak_squeeze_bytes #(.LEN_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string         name;
        logic [1599:0] s;
        logic [1599:0] p;
        int            pos;
        int            r;
        int            len;
        bit            stall;
    } vec_t;

    int            tests = 0;
    int            fails = 0;
    int            perm_seen = 0;
    int            n_acc = 0;
    logic [1599:0] perm_ret = '0;
    logic [7:0]    exp_q[$];
    vec_t          vecs[6];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [1599:0] rand1600();
        logic [1599:0] v;
        for (int k = 0; k < 50; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    // Scoreboard and perm_start monitor, sampled away from the active edge.
    always @(negedge clock) begin
        logic [7:0] e;
        if (bus.perm_start === 1'b1) perm_seen++;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            n_acc++;
            if (exp_q.size() == 0) chk("unexpected_byte", 64'(bus.out_byte) | 64'h100, 64'h0);
            else begin
                e = exp_q.pop_front();
                chk("byte", 64'(bus.out_byte), 64'(e));
            end
        end
    end

    // Permutation model: answers each request 24 cycles later with perm_ret.
    initial begin
        bus.perm_done = 1'b0;
        bus.perm_s_in = '0;
        forever begin
            @(negedge clock);
            if (bus.perm_start === 1'b1) begin
                repeat (24) @(posedge clock);
                #1;
                bus.perm_s_in = perm_ret;
                bus.perm_done = 1'b1;
                @(posedge clock);
                #1 bus.perm_done = 1'b0;
            end
        end
    end

    task automatic run_vec(input vec_t v);
        logic [1599:0] ms;
        logic [7:0]    held;
        int mp, np, cyc, stall_left;
        ms = v.s; mp = v.pos; np = 0;
        for (int k = 0; k < v.len; k++) begin
            if (mp == v.r) begin ms = v.p; mp = 0; np++; end
            exp_q.push_back(ms[8*mp +: 8]);
            mp++;
        end
        perm_ret = v.p; perm_seen = 0; n_acc = 0;
        bus.s_in = v.s; bus.pos_in = v.pos; bus.r = v.r; bus.outlen = 16'(v.len);
        bus.out_ready = 1'b1; bus.start = 1'b1;
        cyc = 0; stall_left = v.stall ? 5 : 0; held = '0;
        while (bus.done !== 1'b1 && cyc < 3000) begin
            @(posedge clock); #1; cyc++;
            if (v.stall && n_acc == 1 && stall_left > 0) begin
                if (stall_left == 5) held = bus.out_byte;
                chk({v.name, "/stall_valid"}, 64'(bus.out_valid), 64'h1);
                chk({v.name, "/stall_byte"}, 64'(bus.out_byte), 64'(held));
                bus.out_ready = 1'b0;
                stall_left--;
            end else bus.out_ready = 1'b1;
        end
        chk({v.name, "/done"}, 64'(bus.done), 64'h1);
        chk({v.name, "/pos_out"}, 64'(bus.pos_out), 64'(mp));
        chk({v.name, "/bytes_left"}, 64'(exp_q.size()), 64'h0);
        chk({v.name, "/perms"}, 64'(perm_seen), 64'(np));
        chk({v.name, "/s_out"}, 64'(bus.s_out == ms), 64'h1);
`ifdef KECCAK_SQZ_PERM_CNT_EN
        chk({v.name, "/perm_count"}, 64'(bus.perm_count), 64'(np));
`endif
        exp_q.delete();
        bus.start = 1'b0; bus.out_ready = 1'b1;
        @(posedge clock); #1;
        chk({v.name, "/idle"}, 64'(bus.done), 64'h0);
    endtask

    initial begin
        int cyc;
        bus.start = 1'b0; bus.s_in = '0; bus.pos_in = '0; bus.r = 32'd168;
        bus.outlen = '0; bus.out_ready = 1'b1;

        vecs[0].name = "t1"; vecs[0].s = rand1600(); vecs[0].s[63:0] = 64'h0706050403020100;
        vecs[0].p = rand1600(); vecs[0].pos = 0; vecs[0].r = 168; vecs[0].len = 4; vecs[0].stall = 0;
        vecs[1].name = "t2"; vecs[1].s = rand1600(); vecs[1].s[20*64 +: 64] = 64'hFFEE << 48;
        vecs[1].p = rand1600(); vecs[1].p[63:0] = 64'h2211;
        vecs[1].pos = 166; vecs[1].r = 168; vecs[1].len = 4; vecs[1].stall = 0;
        vecs[2].name = "t4"; vecs[2].s = rand1600(); vecs[2].p = rand1600();
        vecs[2].pos = 5; vecs[2].r = 136; vecs[2].len = 3; vecs[2].stall = 1;
        vecs[3].name = "t6"; vecs[3].s = rand1600(); vecs[3].p = rand1600();
        vecs[3].pos = 136; vecs[3].r = 136; vecs[3].len = 1; vecs[3].stall = 0;
        vecs[4].name = "long"; vecs[4].s = rand1600(); vecs[4].p = rand1600();
        vecs[4].pos = 100; vecs[4].r = 136; vecs[4].len = 300; vecs[4].stall = 0;
        vecs[5].name = "end_at_r"; vecs[5].s = rand1600(); vecs[5].p = rand1600();
        vecs[5].pos = 130; vecs[5].r = 136; vecs[5].len = 6; vecs[5].stall = 0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_perm_start", 64'(bus.perm_start), 64'h0);
        chk("rst_done", 64'(bus.done), 64'h0);
        chk("rst_pos_out", 64'(bus.pos_out), 64'h0);
        chk("rst_out_byte", 64'(bus.out_byte), 64'h0);
        chk("rst_s_out", 64'(bus.s_out == '0), 64'h1);
`ifdef KECCAK_SQZ_PERM_CNT_EN
        chk("rst_perm_count", 64'(bus.perm_count), 64'h0);
`endif
        reset = 1'b0;
        @(posedge clock); #1;

        // T3: outlen=0 reaches DONE two cycles after start, no output
        perm_seen = 0;
        for (int rep = 0; rep < 2; rep++) begin
            bus.outlen = '0; bus.pos_in = 32'd3; bus.start = 1'b1;
            @(posedge clock); #1;
            chk("t3_done_c1", 64'(bus.done), 64'h0);
            @(posedge clock); #1;
            chk("t3_done_c2", 64'(bus.done), 64'h1);
            chk("t3_pos_out", 64'(bus.pos_out), 64'h3);
            bus.start = 1'b0;
            @(posedge clock); #1;
            chk("t3_idle", 64'(bus.done), 64'h0);
        end
        chk("t3_no_perm", 64'(perm_seen), 64'h0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // T5: reset during PERM_WAIT, late perm_done must be ignored
        perm_ret = rand1600(); perm_seen = 0;
        bus.s_in = rand1600(); bus.pos_in = 32'd168; bus.r = 32'd168; bus.outlen = 16'd2;
        bus.start = 1'b1;
        cyc = 0;
        while (perm_seen == 0 && cyc < 50) begin @(posedge clock); #1; cyc++; end
        chk("t5_perm_req", 64'(perm_seen), 64'h1);
        @(posedge clock); #3;
        reset = 1'b1;
        #1;
        chk("t5_out_valid", 64'(bus.out_valid), 64'h0);
        chk("t5_perm_start", 64'(bus.perm_start), 64'h0);
        chk("t5_done", 64'(bus.done), 64'h0);
        chk("t5_pos_out", 64'(bus.pos_out), 64'h0);
        chk("t5_s_out", 64'(bus.s_out == '0), 64'h1);
        bus.start = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        repeat (30) @(posedge clock);
        #1;
        chk("t5_late_done", 64'(bus.done), 64'h0);
        chk("t5_late_s_out", 64'(bus.s_out == '0), 64'h1);
        vecs[0].name = "t5_t1";
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
